command_issue_unit: RTL and testbench

- Producer end of the decoder's command interface.
- Fetches 16-bit instructions from instruction memory with a req/valid handshake and maintains the PC.
- Presents the current command plus the two previously issued commands to the decode stage every cycle, so forwarding detection sees correct pipeline history.
- Handles downstream stall, branch flush (bubble insertion) and halt.

---
 rtl/command_issue_unit_pkg.sv | 22 ++
 rtl/command_skid_buffer.sv | 35 +++
 rtl/command_issue_unit.sv | 120 ++++++++++++
 tb/tb_command_issue_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/command_issue_unit_pkg.sv
// Shared types and encodings for the command issue unit: word type, FSM states,
// filler word and HLT field constants.
package command_issue_unit_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } state_t;

    // Filler word: class 11, func 1110 -- writes nothing, matches nothing, loads no PC.
    localparam word_t      BUBBLE_WORD = 16'hC0E0;
    localparam logic [1:0] HLT_CLASS   = 2'b11;
    localparam logic [3:0] HLT_FUNC    = 4'b1111;

    function automatic logic is_hlt(input word_t w);
        return (w[15:14] == HLT_CLASS) && (w[7:4] == HLT_FUNC);
    endfunction

endpackage

// File: rtl/command_skid_buffer.sv
// One-entry holding slot for a fetched word (and its address) that arrives while
// the decode stage is stalled.
module command_skid_buffer
    import command_issue_unit_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  clear,
    input  logic  load,
    input  logic  drain,
    input  word_t load_data,
    input  word_t load_pc,
    output logic  full,
    output word_t data,
    output word_t pc
);

    // Clear wins over load so a redirect always discards a stale capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            data <= '0;
            pc   <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            data <= load_data;
            pc   <= load_pc;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/command_issue_unit.sv
// Fetches instruction words, maintains the PC and presents the current command plus
// two slots of issue history to decode, handling stall, branch flush and halt.
module command_issue_unit
    import command_issue_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] BUBBLE   = BUBBLE_WORD
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] command,
    output logic [15:0] before_command,
    output logic [15:0] two_before_command,
    output logic        cmd_valid,
    output logic [15:0] cmd_pc,
    output logic        halted
);

    state_t state;
    word_t  pc;

    logic   skid_full;
    word_t  skid_data;
    word_t  skid_pc;

    logic   fetch_hit;
    logic   advance;
    logic   redirect;
    logic   skid_load;
    logic   skid_drain;
    word_t  next_word;
    word_t  next_pc;
    logic   next_valid;

    assign imem_req  = (state == FETCH) && !skid_full;
    assign imem_addr = pc;

    always_comb begin
        fetch_hit  = imem_req && imem_valid;
        // IDLE ignores stall; FETCH and HALT freeze history while stalled.
        advance    = (state == IDLE) || !stall;
        redirect   = (state == FETCH) && !stall && branch_taken;
        skid_load  = (state == FETCH) && stall && fetch_hit;
        skid_drain = (state == FETCH) && !stall && skid_full;

        next_word  = BUBBLE;
        next_pc    = cmd_pc;
        next_valid = 1'b0;
        if ((state == FETCH) && !redirect) begin
            if (skid_full) begin
                next_word  = skid_data;
                next_pc    = skid_pc;
                next_valid = 1'b1;
            end else if (fetch_hit) begin
                next_word  = imem_data;
                next_pc    = pc;
                next_valid = 1'b1;
            end
        end
    end

    command_skid_buffer u_skid (
        .clock     (clock),
        .reset     (reset),
        .clear     (redirect),
        .load      (skid_load),
        .drain     (skid_drain),
        .load_data (imem_data),
        .load_pc   (pc),
        .full      (skid_full),
        .data      (skid_data),
        .pc        (skid_pc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            pc                 <= RESET_PC;
            command            <= BUBBLE;
            before_command     <= BUBBLE;
            two_before_command <= BUBBLE;
            cmd_valid          <= 1'b0;
            cmd_pc             <= '0;
            halted             <= 1'b0;
        end else begin
            halted <= (state == HALT);

            case (state)
                IDLE:    if (start) state <= FETCH;
                FETCH:   if (advance && next_valid && is_hlt(next_word)) state <= HALT;
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase

            // A word fetched in the redirect cycle is dropped along with its PC step.
            if (redirect) begin
                pc <= branch_target;
            end else if (fetch_hit) begin
                pc <= pc + 16'd1;
            end

            if (advance) begin
                two_before_command <= before_command;
                before_command     <= command;
                command            <= next_word;
                cmd_valid          <= next_valid;
                cmd_pc             <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_command_issue_unit.sv
// Scoreboard bench for command_issue_unit: a memory model answers fetches, program
// order is queued up front and popped as the unit issues real commands.
module tb_command_issue_unit;
    import command_issue_unit_pkg::*;

    localparam logic [15:0] BUB = 16'hC0E0;
    localparam logic [15:0] HLT = 16'hC0F0;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_data;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] command;
    logic [15:0] before_command;
    logic [15:0] two_before_command;
    logic        cmd_valid;
    logic [15:0] cmd_pc;
    logic        halted;

    command_issue_unit #(
        .RESET_PC (16'h0000),
        .BUBBLE   (BUB)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .start              (start),
        .imem_req           (imem_req),
        .imem_addr          (imem_addr),
        .imem_valid         (imem_valid),
        .imem_data          (imem_data),
        .stall              (stall),
        .branch_taken       (branch_taken),
        .branch_target      (branch_target),
        .command            (command),
        .before_command     (before_command),
        .two_before_command (two_before_command),
        .cmd_valid          (cmd_valid),
        .cmd_pc             (cmd_pc),
        .halted             (halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] word;
        logic [15:0] addr;
    } sb_t;

    sb_t         sb[$];
    logic [15:0] mem [0:65535];

    int          n_checks = 0;
    int          n_errors = 0;

    int unsigned lat;
    int unsigned wcnt;
    bit          always_valid;
    logic [15:0] exp_h0, exp_h1, exp_h2, exp_pc0;
    logic        exp_v0;
    bit          seen_valid, gap_en, br_arm, br_pending;
    int          gap, exp_gap;
    logic [15:0] br_pc, br_tgt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_mem();
        imem_valid = always_valid || (imem_req && (wcnt >= lat));
        imem_data  = mem[imem_addr];
    endtask

    task automatic model_reset();
        exp_h0 = BUB; exp_h1 = BUB; exp_h2 = BUB;
        exp_pc0 = '0; exp_v0 = 1'b0;
        seen_valid = 0; gap = 0;
        br_arm = 0; br_pending = 0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 16'hEEEE;
    endtask

    task automatic prog(input logic [15:0] addr, input logic [15:0] word);
        mem[addr] = word;
        sb.push_back('{word: word, addr: addr});
    endtask

    // One clock: apply inputs, then score whatever the edge produced.
    task automatic cycle();
        logic stl, req_b, val_b;
        sb_t  e;
        stl   = stall;
        req_b = imem_req;
        val_b = imem_valid;
        @(posedge clock);
        @(negedge clock);
        if (req_b && val_b) wcnt = 0;
        else if (req_b)     wcnt = wcnt + 1;
        else                wcnt = 0;

        if (!stl) begin
            exp_h2 = exp_h1;
            exp_h1 = exp_h0;
            if (br_pending) begin
                check_eq("branch_bubble_valid", 32'(cmd_valid), 32'd0);
                exp_h0 = BUB; exp_v0 = 1'b0;
                br_pending = 0; branch_taken = 1'b0;
            end else if (cmd_valid) begin
                check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                exp_h0 = BUB; exp_v0 = 1'b1;
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("issue_word", 32'(command), 32'(e.word));
                    check_eq("issue_pc", 32'(cmd_pc), 32'(e.addr));
                    exp_h0 = e.word; exp_pc0 = e.addr;
                    if (gap_en && seen_valid) check_eq("bubble_gap", gap, exp_gap);
                    seen_valid = 1; gap = 0;
                    if (br_arm && e.addr == br_pc) begin
                        br_arm = 0; br_pending = 1;
                        branch_taken = 1'b1; branch_target = br_tgt;
                    end
                end
            end else begin
                exp_h0 = BUB; exp_v0 = 1'b0;
                if (seen_valid) gap++;
            end
        end else begin
            check_eq("stall_valid_hold", 32'(cmd_valid), 32'(exp_v0));
            if (exp_v0) check_eq("stall_pc_hold", 32'(cmd_pc), 32'(exp_pc0));
        end
        check_eq("command", 32'(command), 32'(exp_h0));
        check_eq("before_command", 32'(before_command), 32'(exp_h1));
        check_eq("two_before_command", 32'(two_before_command), 32'(exp_h2));
        drive_mem();
    endtask

    task automatic reset_dut();
        reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        #1;
        check_eq("rst_command", 32'(command), 32'(BUB));
        check_eq("rst_before", 32'(before_command), 32'(BUB));
        check_eq("rst_two_before", 32'(two_before_command), 32'(BUB));
        check_eq("rst_valid", 32'(cmd_valid), 32'd0);
        check_eq("rst_cmd_pc", 32'(cmd_pc), 32'd0);
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'h0000);
        check_eq("rst_halted", 32'(halted), 32'd0);
        model_reset();
        sb.delete();
        wcnt = 0;
        drive_mem();
        @(negedge clock);
        reset = 1'b0;
        drive_mem();
    endtask

    task automatic start_dut();
        drive_mem();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic run_to_halt(input int budget);
        for (int i = 0; i < budget && !halted; i++) cycle();
        check_eq("halt_reached", 32'(halted), 32'd1);
        cycle();
        cycle();
        check_eq("halt_req_low", 32'(imem_req), 32'd0);
        check_eq("halt_cmd_bubble", 32'(command), 32'(BUB));
        check_eq("sb_drained", sb.size(), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !cmd_valid; i++) cycle();
        check_eq(tag, 32'(cmd_valid), 32'd1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = '0; imem_valid = 1'b0; imem_data = '0;
        lat = 0; wcnt = 0; always_valid = 1; gap_en = 0; exp_gap = 0;
        br_pc = '0; br_tgt = '0;
        model_reset();
        #1;

        // Back-to-back issue, then HLT at address 3.
        reset_dut();
        clear_mem();
        prog(16'h0000, 16'hA000); prog(16'h0001, 16'hA001);
        prog(16'h0002, 16'hA002); prog(16'h0003, HLT);
        always_valid = 1;
        start_dut();
        check_eq("t1_req_after_start", 32'(imem_req), 32'd1);
        cycle();
        check_eq("t1_before_bubble", 32'(before_command), 32'(BUB));
        cycle();
        cycle();
        check_eq("t1_two_before", 32'(two_before_command), 32'hA000);
        cycle();
        check_eq("t1_hlt_issued", 32'(command), 32'(HLT));
        check_eq("t1_halted_not_yet", 32'(halted), 32'd0);
        check_eq("t1_req_after_hlt", 32'(imem_req), 32'd0);
        cycle();
        check_eq("t1_halted", 32'(halted), 32'd1);
        run_to_halt(5);

        // Two-cycle memory latency: two bubble slots between real commands.
        reset_dut();
        clear_mem();
        prog(16'h0000, 16'hA100); prog(16'h0001, 16'hA101);
        prog(16'h0002, 16'hA102); prog(16'h0003, 16'hA103);
        prog(16'h0004, HLT);
        always_valid = 0; lat = 2; gap_en = 1; exp_gap = 2;
        start_dut();
        run_to_halt(60);
        gap_en = 0; lat = 0; always_valid = 1;

        // Stall for three cycles while a word returns.
        reset_dut();
        clear_mem();
        for (int i = 0; i < 5; i++) prog(16'(i), 16'hA200 + 16'(i));
        prog(16'h0005, HLT);
        start_dut();
        wait_valid("t3_first_valid");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_eq("t3_stall_req", 32'(imem_req), 32'd0);
            check_eq("t3_stall_pc", 32'(imem_addr), 32'h0002);
        end
        stall = 1'b0;
        cycle();
        check_eq("t3_skid_issue_pc", 32'(cmd_pc), 32'h0001);
        run_to_halt(30);

        // Branch at address 5 to 0x0040; word B000 at address 6 arrives with it.
        reset_dut();
        clear_mem();
        for (int i = 0; i < 5; i++) prog(16'(i), 16'hA300 + 16'(i));
        prog(16'h0005, 16'h9005);
        mem[16'h0006] = 16'hB000;
        prog(16'h0040, 16'hA340);
        prog(16'h0041, HLT);
        br_arm = 1; br_pc = 16'h0005; br_tgt = 16'h0040;
        start_dut();
        for (int i = 0; i < 20 && !br_pending; i++) cycle();
        check_eq("t4_branch_reached", 32'(br_pending), 32'd1);
        check_eq("t4_discard_addr", 32'(imem_addr), 32'h0006);
        check_eq("t4_discard_valid", 32'(imem_valid), 32'd1);
        cycle();
        check_eq("t4_branch_in_before", 32'(before_command), 32'h9005);
        check_eq("t4_target_addr", 32'(imem_addr), 32'h0040);
        run_to_halt(30);

        // Branch near the top of memory: PC wraps FFFF -> 0000; HLT dropped by the flush.
        reset_dut();
        clear_mem();
        prog(16'h0000, 16'h9000);
        prog(16'hFFFE, 16'hA3FE);
        prog(16'hFFFF, 16'hA3FF);
        prog(16'h0000, 16'h9000);
        prog(16'h0001, HLT);
        br_arm = 1; br_pc = 16'h0000; br_tgt = 16'hFFFE;
        start_dut();
        for (int i = 0; i < 20 && !br_pending; i++) cycle();
        cycle();
        check_eq("t5_not_halted", 32'(halted), 32'd0);
        check_eq("t5_target_addr", 32'(imem_addr), 32'hFFFE);
        cycle();
        cycle();
        check_eq("t5_wrap_addr", 32'(imem_addr), 32'h0000);
        run_to_halt(30);

        // Asynchronous reset with the skid buffer full, then restart from RESET_PC.
        reset_dut();
        clear_mem();
        prog(16'h0000, 16'hA500);
        prog(16'h0001, 16'hA501);
        start_dut();
        wait_valid("t6_first_valid");
        stall = 1'b1;
        cycle();
        check_eq("t6_skid_full_req", 32'(imem_req), 32'd0);
        #2;
        reset_dut();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h1234;
        cycle();
        cycle();
        stall = 1'b0; branch_taken = 1'b0;
        clear_mem();
        prog(16'h0000, 16'hA600);
        prog(16'h0001, 16'hA601);
        prog(16'h0002, HLT);
        start_dut();
        check_eq("t6_restart_addr", 32'(imem_addr), 32'h0000);
        check_eq("t6_restart_req", 32'(imem_req), 32'd1);
        run_to_halt(30);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
